sc_arbiter_rr: RTL and testbench

Round-robin arbiter that resolves which of N requesters owns a shared resource. Upstream, the requesters' lines are OR-merged into one "someone wants it" signal; this block works in the other direction and recovers a single, fair, one-hot owner from those lines. It issues grants, holds each grant until the owner releases or times out, then rotates priority. It sits between sensor/button request sources and a shared peripheral, such as the display bus or a score register.

---
 rtl/sc_arbiter_rr_pkg.sv | 21 ++
 rtl/sc_arbiter_rr_if.sv | 27 ++
 rtl/sc_arbiter_rr_pick.sv | 31 +++
 rtl/sc_arbiter_rr.sv | 99 +++++++++
 tb/tb_sc_arbiter_rr.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/sc_arbiter_rr_pkg.sv
// Shared definitions for the sc_arbiter_rr round-robin arbiter:
// FSM state encoding and a width helper.
package sc_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_GRANT   = 2'd1,
        STATE_RELEASE = 2'd2
    } state_e;

    localparam int HOLD_W = 8;

    // ceil(log2(n)), but never below 1 so a single requester still gets a 1-bit ID
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sc_arbiter_rr_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// Handshake: req_In[i] held high while requester i wants the resource; the grant
// is held until req_In[i] drops, done_In pulses, or the hold limit expires.
interface sc_arbiter_rr_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0] sc_arbiter_rr_req_In;
    logic             sc_arbiter_rr_done_In;
    logic [N_REQ-1:0] sc_arbiter_rr_grant_Out;
    logic [ID_W-1:0]  sc_arbiter_rr_grantId_Out;
    logic             sc_arbiter_rr_busy_Out;
    logic             sc_arbiter_rr_timeout_Out;
    logic [1:0]       state_dbg;

    modport master (
        output sc_arbiter_rr_req_In, sc_arbiter_rr_done_In,
        input  sc_arbiter_rr_grant_Out, sc_arbiter_rr_grantId_Out,
               sc_arbiter_rr_busy_Out, sc_arbiter_rr_timeout_Out, state_dbg
    );

    modport slave (
        input  sc_arbiter_rr_req_In, sc_arbiter_rr_done_In,
        output sc_arbiter_rr_grant_Out, sc_arbiter_rr_grantId_Out,
               sc_arbiter_rr_busy_Out, sc_arbiter_rr_timeout_Out, state_dbg
    );
endinterface

// File: rtl/sc_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr_i,
// wrapping modulo N_REQ.
module sc_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  idx_o,
    output logic [N_REQ-1:0] onehot_o
);
    logic [ID_W:0] pos;

    // Scan from the farthest offset down so the nearest request is assigned last
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        pos      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_i} + (ID_W + 1)'(k);
            if (pos >= (ID_W + 1)'(N_REQ)) pos = pos - (ID_W + 1)'(N_REQ);
            if (req_i[pos[ID_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = pos[ID_W-1:0];
            end
        end
        if (valid_o) onehot_o[idx_o] = 1'b1;
    end
endmodule

// File: rtl/sc_arbiter_rr.sv
// Round-robin arbiter: grants one requester at a time, holds the grant until
// release/done/timeout, then rotates priority past the released owner.
module sc_arbiter_rr
    import sc_arbiter_rr_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = clog2_min1(N_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic          sc_arbiter_rr_CLOCK_50,
    input  logic          sc_arbiter_rr_RESET_InHigh,
    sc_arbiter_rr_if.slave bus
);
    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;

    logic                pick_valid;
    logic [ID_W-1:0]     pick_idx;
    logic [N_REQ-1:0]    pick_onehot;
    logic                rel_req, rel_done, rel_time;

    sc_arbiter_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req_i    (bus.sc_arbiter_rr_req_In),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    assign rel_req  = ~|(bus.sc_arbiter_rr_req_In & grant_q);
    assign rel_done = bus.sc_arbiter_rr_done_In;
    assign rel_time = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        id_d      = id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            STATE_IDLE, STATE_RELEASE: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    id_d    = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    state_d = STATE_GRANT;
                end else begin
                    state_d = STATE_IDLE;
                end
            end
            STATE_GRANT: begin
                if (rel_req || rel_done || rel_time) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    timeout_d = rel_time && !rel_req && !rel_done;
                    state_d   = STATE_RELEASE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge sc_arbiter_rr_CLOCK_50) begin
        if (sc_arbiter_rr_RESET_InHigh) begin
            state_q   <= STATE_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.sc_arbiter_rr_grant_Out   = grant_q;
    assign bus.sc_arbiter_rr_grantId_Out = id_q;
    assign bus.sc_arbiter_rr_busy_Out    = busy_q;
    assign bus.sc_arbiter_rr_timeout_Out = timeout_q;
    assign bus.state_dbg                 = state_q;
endmodule

// File: tb/tb_sc_arbiter_rr.sv
// Self-checking bench for sc_arbiter_rr: directed steps plus random traffic,
// compared every cycle against an ownership-level reference model.
module tb_sc_arbiter_rr;
    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_arbiter_rr_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    sc_arbiter_rr #(.N_REQ(N_REQ), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)) dut (
        .sc_arbiter_rr_CLOCK_50    (clk),
        .sc_arbiter_rr_RESET_InHigh(rst),
        .bus                       (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the resource, for how many cycles, and where the next scan starts
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_age   = 0;
    logic m_to    = 1'b0;

    int   to_seen;
    logic prev_busy;
    logic [ID_W-1:0] obs_q[$];
    logic [ID_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [N_REQ-1:0] r;
        logic gone, fin, lim, found;
        r = bus.sc_arbiter_rr_req_In;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_age = 0; m_to = 1'b0;
        end else if (m_owner >= 0) begin
            m_age++;
            gone = !r[m_owner];
            fin  = bus.sc_arbiter_rr_done_In;
            lim  = (m_age == MAX_HOLD);
            m_to = 1'b0;
            if (gone || fin || lim) begin
                m_to    = lim && !gone && !fin;
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
            end
        end else begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && r[(m_ptr + k) % N_REQ]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % N_REQ;
                    m_age   = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [N_REQ-1:0] r, input logic d, input logic rs);
        logic [N_REQ-1:0] exp_grant;
        bus.sc_arbiter_rr_req_In  = r;
        bus.sc_arbiter_rr_done_In = d;
        rst = rs;
        @(posedge clk);
        model_step();
        #1;
        exp_grant = '0;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
        check("grant", 32'(bus.sc_arbiter_rr_grant_Out), 32'(exp_grant));
        check("busy", 32'(bus.sc_arbiter_rr_busy_Out), 32'(m_owner >= 0));
        check("timeout", 32'(bus.sc_arbiter_rr_timeout_Out), 32'(m_to));
        check("busy_vs_grant", 32'(bus.sc_arbiter_rr_busy_Out), 32'(|bus.sc_arbiter_rr_grant_Out));
        if (m_owner >= 0) check("grant_id", 32'(bus.sc_arbiter_rr_grantId_Out), 32'(m_owner));
        if (bus.sc_arbiter_rr_timeout_Out) to_seen++;
        if (bus.sc_arbiter_rr_busy_Out && !prev_busy) obs_q.push_back(bus.sc_arbiter_rr_grantId_Out);
        prev_busy = bus.sc_arbiter_rr_busy_Out;
    endtask

    initial begin
        logic [N_REQ-1:0] r;
        logic             d;
        prev_busy = 1'b0;
        to_seen   = 0;
        bus.sc_arbiter_rr_req_In  = '0;
        bus.sc_arbiter_rr_done_In = 1'b0;
        rst = 1'b1;

        // Reset held with everyone requesting, then first grant to requester 0
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        check("first_grant_after_reset", 32'(bus.sc_arbiter_rr_grant_Out), 32'h1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Single request held three cycles, then dropped
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        check("single_req_id", 32'(bus.sc_arbiter_rr_grantId_Out), 32'd2);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b0);
        check("scan_starts_at_3", 32'(bus.sc_arbiter_rr_grant_Out), 32'h8);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Rotation with done on the third cycle of every grant
        step(4'b1111, 1'b0, 1'b1);
        obs_q.delete();
        prev_busy = 1'b0;
        for (int c = 0; c < 18; c++) step(4'b1111, (m_owner >= 0 && m_age == 2), 1'b0);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++)
            check("rotation_order", (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hdead, 32'(exp_q[i]));
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Timeout: requester 1 held with no done for 40 cycles
        to_seen = 0;
        for (int c = 0; c < 40; c++) step(4'b0010, 1'b0, 1'b0);
        check("timeout_pulses", 32'(to_seen), 32'd2);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Simultaneous done and request drop
        to_seen = 0;
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        step(4'b1110, 1'b1, 1'b0);
        step(4'b1110, 1'b0, 1'b0);
        check("simul_release_next", 32'(bus.sc_arbiter_rr_grant_Out), 32'h2);
        check("simul_release_no_to", 32'(to_seen), 32'd0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // Reset in the middle of requester 3's grant
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b1);
        check("midgrant_reset_drop", 32'(bus.sc_arbiter_rr_grant_Out), 32'h0);
        step(4'b1010, 1'b0, 1'b0);
        check("after_reset_grant1", 32'(bus.sc_arbiter_rr_grant_Out), 32'h2);

        // Random traffic: sticky requests, occasional done and reset
        r = 4'($urandom_range(0, 15));
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 7) == 0);
            step(r, d, ($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
